sprite_loc_ctrl: RTL and testbench
==================================

Name: sprite_loc_ctrl

Overview:
Parametrised successor to the pacman location controller; tracks one sprite's (pacman or ghost) current and next map cell. Moves continuously at a programmable step rate, buffers a requested turn until it becomes legal, and wraps at map edges (tunnels). Uses a valid/ack probe handshake to the collision detector and a req/done handshake to the RAM writer.

Parameters:
X_W, 6, width of x coordinate
Y_W, 5, width of y coordinate
MAP_W, 40, map width in cells; legal x = 0..MAP_W-1
MAP_H, 30, map height in cells; legal y = 0..MAP_H-1
START_X, 20, reset x
START_Y, 20, reset y
WRAP, 1, 1 = edge moves wrap to opposite edge; 0 = edge acts as wall
STEP_DIV, 4, CLOCK_50 cycles per step tick (>=1)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = movement allowed; 0 = freeze tick counter, no new probes
dir_in  in  4  {up,down,left,right} request, one-hot or zero; multi-hot ignored
probe_valid  out  1  candidate cell valid to collision detector
probe_x  out  X_W  candidate x
probe_y  out  Y_W  candidate y
probe_ack  in  1  collision result valid this cycle
probe_wall  in  1  candidate is wall (sampled with probe_ack)
wr_req  out  1  request RAM writer to erase curr and draw next
done  in  1  RAM writer finished
curr_x / curr_y  out  X_W / Y_W  committed location
next_x / next_y  out  X_W / Y_W  location being written (= curr when idle)
heading  out  4  current motion direction, one-hot or 0 (stopped)
moved  out  1  1-cycle pulse when curr updates

Behaviour:
- Reset (reset=0, async): state IDLE; curr=next=(START_X,START_Y); heading=0; pending=0; tick counter=0; tick_flag=0; probe_valid=0; wr_req=0; moved=0.
- Turn buffer: any cycle dir_in is valid one-hot, pending<=dir_in (latest wins). Zero or multi-hot: pending unchanged. pending clears only when adopted as heading.
- Tick: counter counts 0..STEP_DIV-1 while enable=1; wraps and sets tick_flag at STEP_DIV-1. tick_flag cleared when IDLE leaves on it; holds if already set (no accumulation beyond one).
- Candidate(d): up y-1, down y+1, left x-1, right x+1 from curr. Edge: WRAP=1 -> x=0 left gives MAP_W-1, x=MAP_W-1 right gives 0, same for y with MAP_H; WRAP=0 -> off-map candidate counts as wall without probing (no probe_valid).
- States:
  IDLE: if tick_flag & enable & (pending|heading)!=0 -> PROBE_P if pending!=0 else PROBE_H.
  PROBE_P: probe_valid=1, probe=Candidate(pending); hold until probe_ack. wall=0 -> heading<=pending, pending<=0, next<=cand, COMMIT. wall=1 -> PROBE_H if heading!=0 and heading!=pending, else STOP.
  PROBE_H: probe=Candidate(heading); wall=0 -> next<=cand, COMMIT; wall=1 -> STOP.
  STOP: heading<=0 (pending kept), next<=curr, -> IDLE. 1 cycle.
  COMMIT: wr_req=1 until done; on done: curr<=next, moved=1 next cycle, -> IDLE.
- probe_x/probe_y stable while probe_valid=1; probe_valid drops the cycle after ack.
- Latency: tick to probe_valid = 1 cycle; ack to wr_req = 1 cycle; done to curr update = 1 edge.
- enable=0 mid PROBE/COMMIT: in-flight transaction completes; no new one starts.
- done or probe_ack outside their waiting state: ignored.
- Reset mid-operation: abort immediately, all outputs to reset values.

Test Plan:
- Reset, STEP_DIV=4, dir_in=right one cycle, no walls -> probe (21,20) ~4 cycles later; ack wall=0, done -> curr=(21,20), heading=0001, moved pulse; keeps stepping (22,20) each tick with dir_in=0.
- Heading right, pending=up, up cell wall -> probe (x,19) wall=1 then probe (x+1,20) wall=0 -> moves right, pending still 1000; next tick up free -> heading=1000.
- Heading right, right cell wall, pending=0 -> STOP: heading=0, curr unchanged, no wr_req.
- WRAP=1, curr=(39,10), heading right -> probe (0,10); WRAP=0 same -> STOP, probe_valid never 1.
- done held off 10 cycles in COMMIT -> wr_req stays 1, curr unchanged; no extra probe despite ticks; one move after done.
- reset pulsed low during PROBE -> outputs immediately at reset values, curr=(20,20).

Source files
------------

// File: rtl/sprite_loc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_loc_ctrl
//  Description : Location controller for one map sprite (pacman or ghost).
//                Keeps the committed cell (curr) and the cell being written
//                (next). The sprite steps once per step tick along its
//                heading. A requested turn is buffered until it becomes legal.
//                Moves off a map edge either wrap (tunnel) or act as a wall.
//                Each candidate cell is checked with the collision detector
//                over a valid/ack handshake. Each accepted move is handed to
//                the RAM writer over a req/done handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50          in   system clock
//    reset             in   asynchronous reset, active low
//    enable            in   1 = tick counter runs and new probes may start
//    dir_in[3:0]       in   {up,down,left,right} turn request (one-hot/zero)
//    probe_valid       out  candidate cell presented to collision detector
//    probe_x/probe_y   out  candidate cell coordinates
//    probe_ack         in   collision result valid this cycle
//    probe_wall        in   candidate is a wall (qualified by probe_ack)
//    wr_req            out  ask RAM writer to erase curr and draw next
//    done              in   RAM writer finished
//    curr_x/curr_y     out  committed location
//    next_x/next_y     out  location being written (= curr when idle)
//    heading[3:0]      out  current motion direction, one-hot or 0
//    moved             out  one-cycle pulse when curr updates
// ============================================================================
module sprite_loc_ctrl #(
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAP_W    = 40,
  parameter int MAP_H    = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 20,
  parameter int WRAP     = 1,
  parameter int STEP_DIV = 4
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           enable,
  input  logic [3:0]     dir_in,
  output logic           probe_valid,
  output logic [X_W-1:0] probe_x,
  output logic [Y_W-1:0] probe_y,
  input  logic           probe_ack,
  input  logic           probe_wall,
  output logic           wr_req,
  input  logic           done,
  output logic [X_W-1:0] curr_x,
  output logic [Y_W-1:0] curr_y,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output logic [3:0]     heading,
  output logic           moved
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STEP_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [X_W-1:0]     c_X_MAX   = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0]     c_Y_MAX   = Y_W'(MAP_H - 1);
  localparam logic [X_W-1:0]     c_X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0]     c_Y_ONE   = Y_W'(1);
  localparam logic [X_W-1:0]     c_X_RST   = X_W'(START_X);
  localparam logic [Y_W-1:0]     c_Y_RST   = Y_W'(START_Y);

  // Direction bit positions inside the {up,down,left,right} vector
  localparam int c_UP    = 3;
  localparam int c_DOWN  = 2;
  localparam int c_LEFT  = 1;
  localparam int c_RIGHT = 0;

  // State encoding
  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_PROBE_P = 3'd1;
  localparam logic [2:0] c_PROBE_H = 3'd2;
  localparam logic [2:0] c_STOP    = 3'd3;
  localparam logic [2:0] c_COMMIT  = 3'd4;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tick_flag;
  logic               w_tick;
  logic               w_leave_idle;

  logic [3:0]         r_pending;
  logic [3:0]         r_heading;
  logic [3:0]         r_probe_dir;   // direction whose candidate is on the bus
  logic               w_dir_onehot;

  logic [X_W-1:0]     r_curr_x;
  logic [Y_W-1:0]     r_curr_y;
  logic [X_W-1:0]     r_next_x;
  logic [Y_W-1:0]     r_next_y;
  logic               r_moved;

  logic [X_W-1:0]     w_cand_x;
  logic [Y_W-1:0]     w_cand_y;
  logic               w_offmap;
  logic               w_in_probe;
  logic               w_free;
  logic               w_blocked;
  logic               w_adopt;

  // --------------------------------------------------------------------------
  // Step tick: the counter only advances while enabled, and the flag
  // remembers at most one unconsumed tick. A new tick wins over the clear
  // so back-to-back ticks (STEP_DIV = 1) are not lost.
  // --------------------------------------------------------------------------
  assign w_tick       = enable && (r_cnt == c_CNT_MAX);
  assign w_leave_idle = (r_state == c_IDLE) && (w_state_nxt != c_IDLE);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_tick_flag <= 1'b0;
    end else begin
      if (enable) begin
        if (r_cnt == c_CNT_MAX) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
      r_tick_flag <= w_tick || (r_tick_flag && !w_leave_idle);
    end
  end

  // --------------------------------------------------------------------------
  // Candidate cell for the probed direction. It depends only on curr and
  // r_probe_dir, and neither changes during a probe, so the probe bus is
  // stable while probe_valid is high.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cand_x = r_curr_x;
    w_cand_y = r_curr_y;
    w_offmap = 1'b0;
    if (r_probe_dir[c_UP]) begin
      if (r_curr_y == '0) begin
        if (WRAP != 0) w_cand_y = c_Y_MAX;
        else           w_offmap = 1'b1;
      end else begin
        w_cand_y = r_curr_y - c_Y_ONE;
      end
    end else if (r_probe_dir[c_DOWN]) begin
      if (r_curr_y == c_Y_MAX) begin
        if (WRAP != 0) w_cand_y = '0;
        else           w_offmap = 1'b1;
      end else begin
        w_cand_y = r_curr_y + c_Y_ONE;
      end
    end else if (r_probe_dir[c_LEFT]) begin
      if (r_curr_x == '0) begin
        if (WRAP != 0) w_cand_x = c_X_MAX;
        else           w_offmap = 1'b1;
      end else begin
        w_cand_x = r_curr_x - c_X_ONE;
      end
    end else if (r_probe_dir[c_RIGHT]) begin
      if (r_curr_x == c_X_MAX) begin
        if (WRAP != 0) w_cand_x = '0;
        else           w_offmap = 1'b1;
      end else begin
        w_cand_x = r_curr_x + c_X_ONE;
      end
    end
  end

  // An off-map candidate resolves as a wall at once, without a handshake.
  assign w_in_probe = (r_state == c_PROBE_P) || (r_state == c_PROBE_H);
  assign w_free     = !w_offmap && probe_ack && !probe_wall;
  assign w_blocked  = w_offmap || (probe_ack && probe_wall);
  assign w_adopt    = (r_state == c_PROBE_P) && w_free;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (r_tick_flag && enable && ((r_pending | r_heading) != 4'b0000)) begin
          w_state_nxt = (r_pending != 4'b0000) ? c_PROBE_P : c_PROBE_H;
        end
      end
      c_PROBE_P: begin
        if (w_free) begin
          w_state_nxt = c_COMMIT;
        end else if (w_blocked) begin
          // Keep going straight only if that is a different direction
          if ((r_heading != 4'b0000) && (r_heading != r_probe_dir)) begin
            w_state_nxt = c_PROBE_H;
          end else begin
            w_state_nxt = c_STOP;
          end
        end
      end
      c_PROBE_H: begin
        if (w_free) begin
          w_state_nxt = c_COMMIT;
        end else if (w_blocked) begin
          w_state_nxt = c_STOP;
        end
      end
      c_STOP: begin
        w_state_nxt = c_IDLE;
      end
      c_COMMIT: begin
        if (done) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    probe_valid = w_in_probe && !w_offmap;
    wr_req      = (r_state == c_COMMIT);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  assign w_dir_onehot = $onehot(dir_in);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_pending   <= 4'b0000;
      r_heading   <= 4'b0000;
      r_probe_dir <= 4'b0000;
      r_curr_x    <= c_X_RST;
      r_curr_y    <= c_Y_RST;
      r_next_x    <= c_X_RST;
      r_next_y    <= c_Y_RST;
      r_moved     <= 1'b0;
    end else begin
      // Turn buffer: newest valid request wins. The adopted request is
      // cleared only if it is still the one in the buffer.
      if (w_dir_onehot) begin
        r_pending <= dir_in;
      end else if (w_adopt && (r_pending == r_probe_dir)) begin
        r_pending <= 4'b0000;
      end

      // Latch which direction is probed on entry to each probe state
      if (w_leave_idle) begin
        r_probe_dir <= (r_pending != 4'b0000) ? r_pending : r_heading;
      end else if ((r_state == c_PROBE_P) && (w_state_nxt == c_PROBE_H)) begin
        r_probe_dir <= r_heading;
      end

      if (w_adopt) begin
        r_heading <= r_probe_dir;
      end else if (r_state == c_STOP) begin
        r_heading <= 4'b0000;
      end

      if (w_in_probe && w_free) begin
        r_next_x <= w_cand_x;
        r_next_y <= w_cand_y;
      end else if (r_state == c_STOP) begin
        r_next_x <= r_curr_x;
        r_next_y <= r_curr_y;
      end

      if ((r_state == c_COMMIT) && done) begin
        r_curr_x <= r_next_x;
        r_curr_y <= r_next_y;
      end
      r_moved <= (r_state == c_COMMIT) && done;
    end
  end

  assign probe_x = w_cand_x;
  assign probe_y = w_cand_y;
  assign curr_x  = r_curr_x;
  assign curr_y  = r_curr_y;
  assign next_x  = r_next_x;
  assign next_y  = r_next_y;
  assign heading = r_heading;
  assign moved   = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_sprite_loc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_loc_ctrl
//  Description : Directed self-checking bench for sprite_loc_ctrl. One main
//                instance (defaults) plus two edge instances starting at
//                (39,10) with WRAP=1 and WRAP=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_loc_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       enable   = 1'b0;
  logic [3:0] dir_in   = 4'b0000;
  logic       probe_ack  = 1'b0;
  logic       probe_wall = 1'b0;
  logic       done       = 1'b0;

  logic       probe_valid, wr_req, moved;
  logic [5:0] probe_x, curr_x, next_x;
  logic [4:0] probe_y, curr_y, next_y;
  logic [3:0] heading;

  // Edge instances share one set of inputs
  logic [3:0] e_dir  = 4'b0000;
  logic       e_ack  = 1'b0;
  logic       e_wall = 1'b0;
  logic       e_done = 1'b0;

  logic       w1_pv, w1_req, w1_moved;
  logic [5:0] w1_px, w1_cx, w1_nx;
  logic [4:0] w1_py, w1_cy, w1_ny;
  logic [3:0] w1_hd;

  logic       w0_pv, w0_req, w0_moved;
  logic [5:0] w0_px, w0_cx, w0_nx;
  logic [4:0] w0_py, w0_cy, w0_ny;
  logic [3:0] w0_hd;

  int n_tests = 0;
  int n_fail  = 0;
  bit w0_seen = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sprite_loc_ctrl u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .dir_in(dir_in),
    .probe_valid(probe_valid), .probe_x(probe_x), .probe_y(probe_y),
    .probe_ack(probe_ack), .probe_wall(probe_wall),
    .wr_req(wr_req), .done(done),
    .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x), .next_y(next_y),
    .heading(heading), .moved(moved)
  );

  sprite_loc_ctrl #(.START_X(39), .START_Y(10), .WRAP(1)) u_w1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .dir_in(e_dir),
    .probe_valid(w1_pv), .probe_x(w1_px), .probe_y(w1_py),
    .probe_ack(e_ack), .probe_wall(e_wall),
    .wr_req(w1_req), .done(e_done),
    .curr_x(w1_cx), .curr_y(w1_cy), .next_x(w1_nx), .next_y(w1_ny),
    .heading(w1_hd), .moved(w1_moved)
  );

  sprite_loc_ctrl #(.START_X(39), .START_Y(10), .WRAP(0)) u_w0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .dir_in(e_dir),
    .probe_valid(w0_pv), .probe_x(w0_px), .probe_y(w0_py),
    .probe_ack(e_ack), .probe_wall(e_wall),
    .wr_req(w0_req), .done(e_done),
    .curr_x(w0_cx), .curr_y(w0_cy), .next_x(w0_nx), .next_y(w0_ny),
    .heading(w0_hd), .moved(w0_moved)
  );

  // The WRAP=0 instance must never raise probe_valid once armed
  always @(posedge CLOCK_50) begin
    if (w0_pv === 1'b1) w0_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample point just after the rising edge
  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_probe(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (probe_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic ack(input logic wall);
    probe_ack  = 1'b1;
    probe_wall = wall;
    cyc();
    probe_ack  = 1'b0;
    probe_wall = 1'b0;
  endtask

  task automatic finish_done();
    done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  initial begin
    int cnt;
    // ---------------- reset ----------------
    enable = 1'b1;
    cyc(); cyc(); cyc();
    chk("rst_curr_x", 32'(curr_x), 20);
    chk("rst_curr_y", 32'(curr_y), 20);
    chk("rst_next_x", 32'(next_x), 20);
    chk("rst_heading", 32'(heading), 0);
    chk("rst_pvalid", 32'(probe_valid), 0);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_moved", 32'(moved), 0);
    reset = 1'b1;

    // ---------------- first move right ----------------
    dir_in = 4'b0001;
    cyc();
    dir_in = 4'b0000;
    wait_probe("p1_seen");
    chk("p1_x", 32'(probe_x), 21);
    chk("p1_y", 32'(probe_y), 20);
    ack(1'b0);
    chk("p1_wr_req", 32'(wr_req), 1);
    chk("p1_pv_drop", 32'(probe_valid), 0);
    chk("p1_next_x", 32'(next_x), 21);
    chk("p1_heading", 32'(heading), 4'b0001);
    chk("p1_curr_hold", 32'(curr_x), 20);
    finish_done();
    chk("p1_curr_x", 32'(curr_x), 21);
    chk("p1_moved", 32'(moved), 1);
    cyc();
    chk("p1_moved_pulse", 32'(moved), 0);
    chk("p1_req_low", 32'(wr_req), 0);

    // ---------------- continue along heading, buffer an up turn ----------------
    wait_probe("p2_seen");
    chk("p2_x", 32'(probe_x), 22);
    chk("p2_y", 32'(probe_y), 20);
    ack(1'b0);
    dir_in = 4'b1000;
    cyc();
    dir_in = 4'b0000;
    finish_done();
    chk("p2_curr_x", 32'(curr_x), 22);

    // pending up is blocked, fall back to heading
    wait_probe("p3_seen");
    chk("p3_up_x", 32'(probe_x), 22);
    chk("p3_up_y", 32'(probe_y), 19);
    ack(1'b1);
    chk("p3_h_valid", 32'(probe_valid), 1);
    chk("p3_h_x", 32'(probe_x), 23);
    chk("p3_h_y", 32'(probe_y), 20);
    ack(1'b0);
    chk("p3_heading", 32'(heading), 4'b0001);
    chk("p3_wr_req", 32'(wr_req), 1);
    finish_done();
    chk("p3_curr_x", 32'(curr_x), 23);
    chk("p3_curr_y", 32'(curr_y), 20);

    // buffered up is retried and now free
    wait_probe("p4_seen");
    chk("p4_x", 32'(probe_x), 23);
    chk("p4_y", 32'(probe_y), 19);
    ack(1'b0);
    chk("p4_heading", 32'(heading), 4'b1000);
    finish_done();
    chk("p4_curr_y", 32'(curr_y), 19);

    // ---------------- wall ahead, nothing pending -> stop ----------------
    wait_probe("p5_seen");
    chk("p5_y", 32'(probe_y), 18);
    ack(1'b1);
    chk("p5_pv", 32'(probe_valid), 0);
    chk("p5_wr_req", 32'(wr_req), 0);
    cyc();
    chk("p5_heading", 32'(heading), 0);
    chk("p5_curr_y", 32'(curr_y), 19);
    chk("p5_next_y", 32'(next_y), 19);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (probe_valid === 1'b1 || wr_req === 1'b1) cnt++;
      cyc();
    end
    chk("p5_quiet", 32'(cnt), 0);

    // ---------------- latest one-hot wins, multi-hot ignored ----------------
    dir_in = 4'b0100;
    cyc();
    dir_in = 4'b0110;
    cyc();
    dir_in = 4'b0000;
    wait_probe("p6_seen");
    chk("p6_x", 32'(probe_x), 23);
    chk("p6_y", 32'(probe_y), 20);
    ack(1'b0);

    // ---------------- done held off in COMMIT ----------------
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (wr_req !== 1'b1 || curr_y !== 5'd19 || probe_valid !== 1'b0) cnt++;
    end
    chk("p6_hold_bad_cycles", 32'(cnt), 0);
    finish_done();
    chk("p6_curr_y", 32'(curr_y), 20);
    chk("p6_moved", 32'(moved), 1);
    wait_probe("p7_seen");
    chk("p7_y", 32'(probe_y), 21);

    // ---------------- reset during PROBE ----------------
    reset = 1'b0;
    #1;
    chk("ra_pv", 32'(probe_valid), 0);
    chk("ra_curr_x", 32'(curr_x), 20);
    chk("ra_curr_y", 32'(curr_y), 20);
    chk("ra_heading", 32'(heading), 0);
    chk("ra_wr_req", 32'(wr_req), 0);
    cyc();
    reset = 1'b1;

    // ---------------- enable low blocks new probes ----------------
    enable = 1'b0;
    dir_in = 4'b0001;
    cyc();
    dir_in = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (probe_valid === 1'b1) cnt++;
      cyc();
    end
    chk("en_quiet", 32'(cnt), 0);
    enable = 1'b1;
    wait_probe("en_seen");
    chk("en_x", 32'(probe_x), 21);
    ack(1'b0);
    finish_done();
    chk("en_curr_x", 32'(curr_x), 21);

    // ---------------- map edge: wrap vs wall ----------------
    w0_seen = 1'b0;
    e_dir = 4'b0001;
    cyc();
    e_dir = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (w1_pv === 1'b1) begin
        cnt = 1;
        break;
      end
      cyc();
    end
    chk("wrap_seen", 32'(cnt), 1);
    chk("wrap_x", 32'(w1_px), 0);
    chk("wrap_y", 32'(w1_py), 10);
    e_ack = 1'b1;
    cyc();
    e_ack = 1'b0;
    e_done = 1'b1;
    cyc();
    e_done = 1'b0;
    chk("wrap_curr_x", 32'(w1_cx), 0);
    chk("wrap_heading", 32'(w1_hd), 4'b0001);
    for (int i = 0; i < 8; i++) cyc();
    chk("wall_no_probe", 32'(w0_seen), 0);
    chk("wall_curr_x", 32'(w0_cx), 39);
    chk("wall_heading", 32'(w0_hd), 0);
    chk("wall_wr_req", 32'(w0_req), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
